// File: rtl/dreg_bit.sv
// ============================================================================
// dreg_bit : one-bit edge-triggered D flop with load enable, async reset
// Revision : 1.0
// ============================================================================
`default_nettype none

module dreg_bit #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk1,
  input  logic rst_n,
  input  logic en,
  input  logic d,
  output logic q,
  output logic qn
);

  logic stored;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      stored <= RESET_VALUE;
    end else if (en) begin
      stored <= d;
    end
  end

  // Both outputs come from the single state bit so they can never disagree.
  assign q  = stored;
  assign qn = ~stored;

endmodule

`default_nettype wire

// File: rtl/dreg_cell.sv
// ============================================================================
// dreg_cell : WIDTH-bit D register, per-bit reset value, true/complement out
// Revision  : 1.0
// ============================================================================
`default_nettype none

module dreg_cell #(
  parameter int              WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int              CLK2Q_DELAY = 0
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn
);

  // CLK2Q_DELAY is a simulation-only parameter; the storage path is
  // zero-delay, so the value is only range-checked here.
  if (WIDTH < 1 || WIDTH > 64 || CLK2Q_DELAY < 0) begin : g_bad_params
    $error("dreg_cell: illegal parameter value");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dreg_bit #(
      .RESET_VALUE (RESET_VALUE[i])
    ) u_bit (
      .clk1  (clk1),
      .rst_n (rst_n),
      .en    (en),
      .d     (d[i]),
      .q     (q[i]),
      .qn    (qn[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_dreg_cell.sv
// Self-checking bench for dreg_cell: 8-bit register, 1-bit shift chain, 4-bit
// register with a non-zero reset value.
`default_nettype none

module tb_dreg_cell;

  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  int checks = 0;
  int errors = 0;

  // 8-bit DUT, reset value 0
  logic       rst_n8 = 1'b0;
  logic       en8 = 1'b0;
  logic [7:0] d8 = '0;
  logic [7:0] q8, qn8;
  logic [7:0] model8 = '0;
  logic [7:0] exp8_q[$];

  dreg_cell #(.WIDTH(8), .RESET_VALUE(8'h00), .CLK2Q_DELAY(0)) u_dut8 (
    .clk1 (clk1), .rst_n (rst_n8), .en (en8), .d (d8), .q (q8), .qn (qn8)
  );

  // Shift chain of eight 1-bit cells
  logic       rst_nc = 1'b0;
  logic       chain_d0 = 1'b0;
  logic [7:0] q_chain, qn_chain;
  logic [8:0] chain_in;
  logic [7:0] model_chain = '0;
  logic [7:0] exp_chain[$];
  assign chain_in = {q_chain, chain_d0};

  for (genvar i = 0; i < 8; i++) begin : g_chain
    dreg_cell #(.WIDTH(1), .RESET_VALUE(1'b0), .CLK2Q_DELAY(0)) u_stage (
      .clk1 (clk1), .rst_n (rst_nc), .en (1'b1), .d (chain_in[i]),
      .q (q_chain[i]), .qn (qn_chain[i])
    );
  end

  // 4-bit DUT, reset value 1010
  logic       rst_n4 = 1'b0;
  logic       en4 = 1'b0;
  logic [3:0] d4 = '0;
  logic [3:0] q4, qn4;

  dreg_cell #(.WIDTH(4), .RESET_VALUE(4'b1010), .CLK2Q_DELAY(0)) u_dut4 (
    .clk1 (clk1), .rst_n (rst_n4), .en (en4), .d (d4), .q (q4), .qn (qn4)
  );

  task automatic step8(input logic [7:0] dv, input logic ev, input string name);
    logic [7:0] e;
    d8  = dv;
    en8 = ev;
    if (ev) model8 = dv;
    exp8_q.push_back(model8);
    @(posedge clk1);
    #1;
    e = exp8_q.pop_front();
    checks++;
    if (q8 !== e || qn8 !== ~e) begin
      errors++;
      $display("FAIL %s: q=%h qn=%h expected q=%h qn=%h", name, q8, qn8, e, ~e);
    end
  endtask

  task automatic test_reset();
    rst_n8 = 1'b0;
    d8     = 8'hFF;
    en8    = 1'b1;
    model8 = 8'h00;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk1);
      #1;
      checks++;
      if (q8 !== 8'h00 || qn8 !== 8'hFF) begin
        errors++;
        $display("FAIL reset_hold[%0d]: q=%h qn=%h expected q=00 qn=ff", k, q8, qn8);
      end
    end
  endtask

  task automatic test_capture();
    rst_n8 = 1'b1;
    step8(8'h3C, 1'b1, "capture_3c");
    step8(8'hC3, 1'b1, "capture_c3");
  endtask

  task automatic test_async_reset();
    step8(8'hA5, 1'b1, "load_a5");
    #2 rst_n8 = 1'b0;
    model8 = 8'h00;
    #1;
    checks++;
    if (q8 !== 8'h00 || qn8 !== 8'hFF) begin
      errors++;
      $display("FAIL async_reset: q=%h qn=%h expected q=00 qn=ff", q8, qn8);
    end
    #1 rst_n8 = 1'b1;
  endtask

  task automatic test_enable_hold();
    step8(8'h5A, 1'b1, "load_5a");
    for (int k = 0; k < 4; k++) step8(8'hFF, 1'b0, "enable_hold");
    step8(8'hFF, 1'b1, "enable_reload");
  endtask

  task automatic test_setup_sampling();
    d8  = 8'h11;
    en8 = 1'b1;
    #2 d8 = 8'h22;
    #2 d8 = 8'h33;
    checks++;
    if (q8 !== model8) begin
      errors++;
      $display("FAIL mid_cycle_d: q=%h expected %h", q8, model8);
    end
    step8(8'h44, 1'b1, "sample_at_edge");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 12; k++) begin
      step8(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), "random_step");
    end
  endtask

  task automatic test_shift_chain();
    logic [7:0] e;
    rst_nc = 1'b0;
    @(posedge clk1);
    #1 rst_nc = 1'b1;
    model_chain = '0;
    for (int k = 0; k < 9; k++) begin
      chain_d0 = (k == 0);
      model_chain = {model_chain[6:0], chain_d0};
      exp_chain.push_back(model_chain);
      @(posedge clk1);
      #1;
      e = exp_chain.pop_front();
      checks++;
      if (q_chain !== e || qn_chain !== ~e) begin
        errors++;
        $display("FAIL shift_chain[%0d]: q=%b qn=%b expected q=%b", k, q_chain, qn_chain, e);
      end
    end
  endtask

  task automatic test_nonzero_reset();
    rst_n4 = 1'b0;
    d4     = 4'b1111;
    en4    = 1'b1;
    #1;
    checks++;
    if (q4 !== 4'b1010 || qn4 !== 4'b0101) begin
      errors++;
      $display("FAIL nonzero_reset: q=%b qn=%b expected q=1010 qn=0101", q4, qn4);
    end
    @(posedge clk1);
    #1 rst_n4 = 1'b1;
    d4 = 4'b0011;
    @(posedge clk1);
    #1;
    checks++;
    if (q4 !== 4'b0011 || qn4 !== 4'b1100) begin
      errors++;
      $display("FAIL w4_load: q=%b qn=%b expected q=0011 qn=1100", q4, qn4);
    end
    d4 = 4'b1111;
    @(posedge clk1);
    rst_n4 = 1'b0;
    #1;
    checks++;
    if (q4 !== 4'b1010 || qn4 !== 4'b0101) begin
      errors++;
      $display("FAIL reset_at_edge: q=%b qn=%b expected q=1010 qn=0101", q4, qn4);
    end
    @(posedge clk1);
    #1;
    checks++;
    if (q4 !== 4'b1010) begin
      errors++;
      $display("FAIL reset_ignores_clk: q=%b expected q=1010", q4);
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_async_reset();
    test_enable_hold();
    test_setup_sampling();
    test_back_to_back();
    test_shift_chain();
    test_nonzero_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
